// File: rtl/speaker_tone_gen.sv
// rtl/speaker_tone_gen.sv - square-wave tone generator with sequential half-period divider
//
// Purpose: converts a requested tone frequency (Hz) into a square wave on the
// speaker pin. The half-period in clock cycles, floor(CLK_HZ / (2*f)), is
// computed by a one-bit-per-cycle restoring divider. Tone changes never
// truncate the half-period that is already running.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset      synchronous, active-low reset
//   frequency  requested tone in Hz (values below MIN_HZ mean silence)
//   enable     1 = audio output permitted, 0 = muted
//   speaker    registered square-wave drive
//   note_on    registered, high while a tone is being generated
//   busy       registered, high while the divider is running

module speaker_tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int MIN_HZ = 20,
  parameter int CNT_W  = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] frequency,
  input  logic        enable,
  output logic        speaker,
  output logic        note_on,
  output logic        busy
);

  localparam int                STEP_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  // floor(CLK/(2f)) == floor(floor(CLK/2)/f), so the dividend fits in CNT_W bits
  localparam logic [CNT_W-1:0]  HALF_CLK  = CNT_W'(CLK_HZ / 2);
  localparam logic [10:0]       MIN_F     = 11'(MIN_HZ);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RUN} state_t;

  state_t            r_state;
  logic [10:0]       r_freq_q;
  logic [10:0]       r_active_freq;
  logic [10:0]       r_div_freq;
  logic [CNT_W-1:0]  r_pending_half;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_div_work;
  logic [10:0]       r_div_rem;
  logic [STEP_W-1:0] r_div_step;
  logic              r_speaker;
  logic              r_note_on;
  logic              r_busy;
  logic              r_en_q;

  logic              w_new_req;
  logic              w_silent;
  logic              w_ge;
  logic [11:0]       w_rem_shift;
  logic [10:0]       w_rem_diff;
  logic [10:0]       w_rem_next;
  logic [CNT_W-1:0]  w_work_next;

  // While dividing, a request is anything that differs from the value being
  // divided; otherwise it is anything that differs from the value playing.
  assign w_new_req   = (r_state == S_DIV) ? (r_freq_q != r_div_freq)
                                          : (r_freq_q != r_active_freq);
  assign w_silent    = (r_freq_q < MIN_F);

  // Restoring division step. r_div_work shifts the dividend out at the top
  // and the quotient in at the bottom. The remainder stays below the divisor,
  // so the 11-bit difference is exact whenever the subtraction is taken.
  assign w_rem_shift = {r_div_rem, r_div_work[CNT_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_div_freq});
  assign w_rem_diff  = w_rem_shift[10:0] - r_div_freq;
  assign w_rem_next  = w_ge ? w_rem_diff : w_rem_shift[10:0];
  assign w_work_next = {r_div_work[CNT_W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_freq_q       <= '0;
      r_active_freq  <= '0;
      r_div_freq     <= '0;
      r_pending_half <= '0;
      r_cnt          <= '0;
      r_div_work     <= '0;
      r_div_rem      <= '0;
      r_div_step     <= '0;
      r_speaker      <= 1'b0;
      r_note_on      <= 1'b0;
      r_busy         <= 1'b0;
      r_en_q         <= 1'b0;
    end else begin
      r_freq_q <= frequency;
      r_en_q   <= enable;

      // Waveform engine: runs whenever a tone is live, including while a new
      // half-period is being divided, so the old tone continues undisturbed.
      if (r_note_on) begin
        if (!enable) begin
          r_speaker <= 1'b0;
          r_cnt     <= r_pending_half - ONE;
        end else if (!r_en_q) begin
          // first enabled cycle after a mute: start a fresh low half-period
          r_cnt <= r_pending_half - ONE;
        end else if (r_cnt == '0) begin
          r_speaker <= ~r_speaker;
          r_cnt     <= r_pending_half - ONE;
        end else begin
          r_cnt <= r_cnt - ONE;
        end
      end

      // Later assignments here take priority over the waveform engine above.
      if (w_new_req && w_silent) begin
        r_state       <= S_IDLE;
        r_active_freq <= r_freq_q;
        r_speaker     <= 1'b0;
        r_note_on     <= 1'b0;
        r_busy        <= 1'b0;
        r_cnt         <= '0;
        r_div_work    <= '0;
        r_div_rem     <= '0;
        r_div_step    <= '0;
      end else if (w_new_req) begin
        r_state    <= S_DIV;
        r_busy     <= 1'b1;
        r_div_freq <= r_freq_q;
        r_div_work <= HALF_CLK;
        r_div_rem  <= '0;
        r_div_step <= '0;
      end else if (r_state == S_DIV) begin
        r_div_work <= w_work_next;
        r_div_rem  <= w_rem_next;
        r_div_step <= r_div_step + STEP_W'(1);
        if (r_div_step == LAST_STEP) begin
          r_pending_half <= w_work_next;
          r_active_freq  <= r_div_freq;
          r_busy         <= 1'b0;
          r_state        <= S_RUN;
          // A tone already playing adopts the new half at its next reload.
          if (!r_note_on) begin
            r_cnt     <= w_work_next - ONE;
            r_speaker <= 1'b0;
            r_note_on <= 1'b1;
          end
        end
      end
    end
  end

  assign speaker = r_speaker;
  assign note_on = r_note_on;
  assign busy    = r_busy;

endmodule

// File: tb/tb_speaker_tone_gen.sv
// tb/tb_speaker_tone_gen.sv - self-checking bench for speaker_tone_gen

module tb_speaker_tone_gen;

  localparam int CLK_HZ = 1_000_000;
  localparam int MIN_HZ = 20;
  localparam int CNT_W  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] frequency;
  logic        speaker;
  logic        note_on;
  logic        busy;

  speaker_tone_gen #(
    .CLK_HZ(CLK_HZ),
    .MIN_HZ(MIN_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .frequency(frequency),
    .enable   (enable),
    .speaker  (speaker),
    .note_on  (note_on),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // edge counter: after rising edge E, cyc == E
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event recorder, sampled on the falling edge
  logic prev_spk  = 1'b0;
  logic prev_busy = 1'b0;
  int   tog_q[$];
  int   last_tog  = 0;
  int   busy_rise = -1;
  int   busy_fall = -1;
  int   n_rise    = 0;

  always @(negedge clk) begin
    if (speaker !== prev_spk) begin
      tog_q.push_back(cyc);
      last_tog = cyc;
    end
    if (busy === 1'b1 && prev_busy === 1'b0) begin
      busy_rise = cyc;
      n_rise    = n_rise + 1;
    end
    if (busy === 1'b0 && prev_busy === 1'b1) busy_fall = cyc;
    prev_spk  = speaker;
    prev_busy = busy;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int half_of(input int f);
    return CLK_HZ / (2 * f);
  endfunction

  task automatic check_tog(input string tag, input int idx, input int exp);
    int got;
    got = -1;
    if (tog_q.size() > idx) got = tog_q[idx];
    check_eq(tag, got, exp);
  endtask

  int last_c;
  int run_h;

  // silence, then start tone f; checks busy window and first three edges
  task automatic play_from_idle(input int f);
    int ta, c;
    frequency = 11'd0;
    repeat (4) step();
    check_eq("idle_note_on", note_on, 0);
    check_eq("idle_speaker", speaker, 0);
    tog_q.delete();
    busy_fall = -1;
    n_rise    = 0;
    ta        = cyc;
    frequency = 11'(f);
    run_h     = half_of(f);
    step();
    check_eq("busy_not_yet", busy, 0);
    step();
    check_eq("busy_on", busy, 1);
    repeat (CNT_W + 2) step();
    c = ta + 2 + CNT_W;
    check_eq("busy_rise_edge", busy_rise, ta + 2);
    check_eq("busy_fall_edge", busy_fall, c);
    check_eq("busy_single_rise", n_rise, 1);
    check_eq("note_on_run", note_on, 1);
    last_c = c;
    while (cyc < c + 3 * run_h + 2) step();
    check_tog("tone_edge0", 0, c + run_h);
    check_tog("tone_edge1", 1, c + 2 * run_h);
    check_tog("tone_edge2", 2, c + 3 * run_h);
  endtask

  // tone change while running: current half finishes, no runt pulse
  task automatic switch_tone(input int f1, input int f2);
    int ta, c, b, h1, h2;
    int expv[4];
    play_from_idle(f1);
    h1 = run_h;
    repeat ($urandom_range(1, 1200)) step();
    ta        = cyc;
    frequency = 11'(f2);
    h2        = half_of(f2);
    c         = ta + 2 + CNT_W;
    step();
    b = (last_tog > last_c) ? last_tog : last_c;
    tog_q.delete();
    busy_fall = -1;
    for (int i = 0; i < 4; i++) begin
      b       = b + ((b > c) ? h2 : h1);
      expv[i] = b;
    end
    repeat (4) step();
    check_eq("switch_note_on", note_on, 1);
    while (cyc < expv[3] + 2) step();
    check_eq("switch_busy_fall", busy_fall, c);
    for (int i = 0; i < 4; i++) check_tog("switch_edge", i, expv[i]);
  endtask

  // second request during division restarts it
  task automatic restart_div(input int f2);
    int tb2, c, h;
    frequency = 11'd0;
    repeat (4) step();
    tog_q.delete();
    busy_fall = -1;
    n_rise    = 0;
    frequency = 11'd440;
    repeat ($urandom_range(3, 15)) step();
    check_eq("restart_busy_mid", busy, 1);
    tb2       = cyc;
    frequency = 11'(f2);
    h         = half_of(f2);
    c         = tb2 + 2 + CNT_W;
    repeat (CNT_W + 4) step();
    check_eq("restart_busy_fall", busy_fall, c);
    check_eq("restart_single_rise", n_rise, 1);
    while (cyc < c + 2 * h + 2) step();
    check_tog("restart_edge0", 0, c + h);
    check_tog("restart_edge1", 1, c + 2 * h);
  endtask

  // silent request while a tone plays
  task automatic silence(input int tgt);
    play_from_idle($urandom_range(500, 2047));
    repeat ($urandom_range(1, 500)) step();
    frequency = 11'(tgt);
    step();
    check_eq("silence_hold_note", note_on, 1);
    step();
    check_eq("silence_note_off", note_on, 0);
    check_eq("silence_speaker", speaker, 0);
    check_eq("silence_busy", busy, 0);
  endtask

  int f2r, bad, tr, h, c;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: reached cycle %0d, required finish before 95000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    frequency = 11'd0;
    repeat (3) step();
    check_eq("reset_speaker", speaker, 0);
    check_eq("reset_note_on", note_on, 0);
    check_eq("reset_busy", busy, 0);
    reset = 1'b1;
    repeat (3) step();
    check_eq("post_reset_busy", busy, 0);
    check_eq("post_reset_note_on", note_on, 0);

    play_from_idle(440);
    for (int it = 0; it < 3; it++) play_from_idle($urandom_range(500, 2047));

    switch_tone(440, 2047);
    switch_tone($urandom_range(500, 2047), $urandom_range(500, 2047));

    restart_div(262);
    f2r = $urandom_range(500, 2047);
    if (f2r == 440) f2r = 441;
    restart_div(f2r);

    silence(0);
    silence(10);

    // mute and unmute while running
    play_from_idle(440);
    repeat ($urandom_range(1, 2000)) step();
    enable = 1'b0;
    step();
    check_eq("mute_speaker", speaker, 0);
    bad = 0;
    repeat (50) begin
      step();
      if (speaker !== 1'b0 || note_on !== 1'b1) bad++;
    end
    check_eq("mute_window_bad_samples", bad, 0);
    tog_q.delete();
    tr     = cyc;
    enable = 1'b1;
    while (cyc < tr + 1 + 2 * run_h + 2) step();
    check_tog("unmute_edge0", 0, tr + 1 + run_h);
    check_tog("unmute_edge1", 1, tr + 1 + 2 * run_h);

    // reset during division, then release with frequency held
    frequency = 11'd0;
    repeat (4) step();
    frequency = 11'd700;
    repeat (5) step();
    check_eq("rst_busy_pre", busy, 1);
    reset = 1'b0;
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_note_on", note_on, 0);
    check_eq("rst_speaker", speaker, 0);
    step();
    tog_q.delete();
    n_rise    = 0;
    busy_fall = -1;
    tr        = cyc;
    reset     = 1'b1;
    h         = half_of(700);
    c         = tr + 2 + CNT_W;
    repeat (CNT_W + 4) step();
    check_eq("rel_busy_rise", busy_rise, tr + 2);
    check_eq("rel_busy_fall", busy_fall, c);
    while (cyc < c + 2 * h + 2) step();
    check_tog("rel_edge0", 0, c + h);
    check_tog("rel_edge1", 1, c + 2 * h);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
